// File: rtl/mirror_angle_gen.sv
// rtl/mirror_angle_gen.sv - mirror angle sweep generator fed by IEEE-754 amplitude/step
// Define MIRROR_ACC_SAT_EN for saturating accumulation; default build wraps.
module mirror_angle_gen #(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int NUMBER_OF_FRAMES_P = 5
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        thetaM_valid_i,
  input  logic [31:0] thetaM_i,
  input  logic        mirrorStep_valid_i,
  input  logic [31:0] mirrorStep_i,
  input  logic        start_i,
  input  logic        tick_i,
  input  logic        angle_ready_i,
  output logic        angle_valid_o,
  output logic [31:0] angle_o,
  output logic [15:0] point_idx_o,
  output logic [7:0]  frame_idx_o,
  output logic        sweep_done_o,
  output logic        busy_o,
  output logic        conv_err_o,
  output logic        overrun_o
);

  localparam int          N_C    = POINTS_PER_LINE_P * NUMBER_OF_FRAMES_P;
  localparam logic [15:0] N_L    = 16'(N_C);
  localparam logic [15:0] P_LAST = 16'(POINTS_PER_LINE_P - 1);

  typedef enum logic [1:0] {IDLE, READY, RUN} state_t;

  // Returns {err, Q8.24}; out-of-range and NaN saturate with err set.
  function automatic logic [32:0] float_to_q(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] mag;
    logic [32:0] r;
    e   = f[30:23];
    mag = {8'd0, 1'b1, f[22:0]};
    r   = 33'd0;
    if (e == 8'd0) begin
      r = 33'd0;
    end else if (e >= 8'd134) begin
      if (f[31] && !(e == 8'hFF && f[22:0] != 23'd0)) r = {1'b1, 32'h8000_0000};
      else r = {1'b1, 32'h7FFF_FFFF};
    end else begin
      if (e >= 8'd126) mag = mag << (e - 8'd126);
      else mag = mag >> (8'd126 - e);
      r = {1'b0, f[31] ? (~mag + 32'd1) : mag};
    end
    return r;
  endfunction

  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
`ifdef MIRROR_ACC_SAT_EN
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  state_t      state;
  logic        theta_ld, step_ld;
  logic [31:0] theta_sh, step_sh, step_w, acc;
  logic [15:0] k_q, p_cnt;
  logic [7:0]  f_cnt;
  logic [32:0] conv_t, conv_s;
  logic        pts_left, slot_free, emit, accept, start_ok;

  assign conv_t    = float_to_q(thetaM_i);
  assign conv_s    = float_to_q(mirrorStep_i);
  assign pts_left  = (k_q != N_L);
  assign slot_free = !angle_valid_o || angle_ready_i;
  assign emit      = (state == RUN) && tick_i && pts_left && slot_free;
  assign accept    = angle_valid_o && angle_ready_i;
  assign start_ok  = (state == READY) && start_i;
  assign busy_o    = (state == RUN);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state         <= IDLE;
      theta_ld      <= 1'b0;
      step_ld       <= 1'b0;
      theta_sh      <= 32'd0;
      step_sh       <= 32'd0;
      step_w        <= 32'd0;
      acc           <= 32'd0;
      k_q           <= 16'd0;
      p_cnt         <= 16'd0;
      f_cnt         <= 8'd0;
      angle_valid_o <= 1'b0;
      angle_o       <= 32'd0;
      point_idx_o   <= 16'd0;
      frame_idx_o   <= 8'd0;
      sweep_done_o  <= 1'b0;
      conv_err_o    <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      sweep_done_o <= 1'b0;
      if (thetaM_valid_i) begin
        theta_sh <= conv_t[31:0];
        theta_ld <= 1'b1;
      end
      if (mirrorStep_valid_i) begin
        step_sh <= conv_s[31:0];
        step_ld <= 1'b1;
      end
      // A new conversion error in the start cycle survives the clear.
      conv_err_o <= (start_ok ? 1'b0 : conv_err_o)
                  | (thetaM_valid_i & conv_t[32])
                  | (mirrorStep_valid_i & conv_s[32]);
      case (state)
        IDLE: begin
          if (theta_ld && step_ld) state <= READY;
        end
        READY: begin
          if (start_i) begin
            step_w    <= step_sh;
            acc       <= ~theta_sh + 32'd1;
            k_q       <= 16'd0;
            p_cnt     <= 16'd0;
            f_cnt     <= 8'd0;
            overrun_o <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (emit) begin
            angle_valid_o <= 1'b1;
            angle_o       <= acc;
            point_idx_o   <= p_cnt;
            frame_idx_o   <= f_cnt;
            acc           <= acc_add(acc, step_w);
            k_q           <= k_q + 16'd1;
            if (p_cnt == P_LAST) begin
              p_cnt <= 16'd0;
              f_cnt <= f_cnt + 8'd1;
            end else begin
              p_cnt <= p_cnt + 16'd1;
            end
          end else begin
            if (tick_i && pts_left) overrun_o <= 1'b1;
            if (accept) begin
              angle_valid_o <= 1'b0;
              if (!pts_left) begin
                sweep_done_o <= 1'b1;
                state        <= READY;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mirror_angle_gen.sv
// tb/tb_mirror_angle_gen.sv - self-checking bench for mirror_angle_gen (P=4, F=2)
module tb_mirror_angle_gen;

  localparam int P = 4;
  localparam int F = 2;
  localparam int N = P * F;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        thetaM_valid_i = 1'b0;
  logic [31:0] thetaM_i = 32'd0;
  logic        mirrorStep_valid_i = 1'b0;
  logic [31:0] mirrorStep_i = 32'd0;
  logic        start_i = 1'b0;
  logic        tick_i = 1'b0;
  logic        angle_ready_i = 1'b0;
  logic        angle_valid_o;
  logic [31:0] angle_o;
  logic [15:0] point_idx_o;
  logic [7:0]  frame_idx_o;
  logic        sweep_done_o, busy_o, conv_err_o, overrun_o;

  int n_cmp = 0;
  int n_fail = 0;

  mirror_angle_gen #(.POINTS_PER_LINE_P(P), .NUMBER_OF_FRAMES_P(F)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .thetaM_valid_i(thetaM_valid_i), .thetaM_i(thetaM_i),
    .mirrorStep_valid_i(mirrorStep_valid_i), .mirrorStep_i(mirrorStep_i),
    .start_i(start_i), .tick_i(tick_i), .angle_ready_i(angle_ready_i),
    .angle_valid_o(angle_valid_o), .angle_o(angle_o),
    .point_idx_o(point_idx_o), .frame_idx_o(frame_idx_o),
    .sweep_done_o(sweep_done_o), .busy_o(busy_o),
    .conv_err_o(conv_err_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: state 0 idle, 1 ready, 2 run; angles from closed form.
  int          m_state = 0;
  bit          m_lt = 0, m_ls = 0, m_full = 0, m_done = 0, m_ovr = 0, m_err = 0;
  logic [31:0] m_sh_t = 0, m_sh_s = 0, m_w_t = 0, m_w_s = 0, m_angle = 0;
  int          m_k = 0, m_pidx = 0, m_fidx = 0;

  function automatic logic [32:0] q_of(input logic [31:0] f);
    int          e;
    real         mag;
    logic [31:0] q, sat;
    e   = int'(f[30:23]);
    sat = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e == 0) return 33'd0;
    if (e == 255) return (f[22:0] != 23'd0) ? {1'b1, 32'h7FFF_FFFF} : {1'b1, sat};
    mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    if (mag >= 128.0) return {1'b1, sat};
    q = 32'($rtoi(mag * 16777216.0));
    return {1'b0, f[31] ? -q : q};
  endfunction

  function automatic logic [31:0] exp_angle(input int k);
    longint v;
    v = -longint'($signed(m_w_t)) + longint'(k) * longint'($signed(m_w_s));
`ifdef MIRROR_ACC_SAT_EN
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
`endif
    return v[31:0];
  endfunction

  function automatic void model_reset();
    m_state = 0; m_lt = 0; m_ls = 0; m_full = 0; m_done = 0; m_ovr = 0; m_err = 0;
    m_sh_t = 0; m_sh_s = 0; m_w_t = 0; m_w_s = 0; m_angle = 0;
    m_k = 0; m_pidx = 0; m_fidx = 0;
  endfunction

  function automatic void model_edge();
    logic [32:0] q;
    m_done = 0;
    if (m_state == 0) begin
      if (m_lt && m_ls) m_state = 1;
    end else if (m_state == 1) begin
      if (start_i) begin
        m_w_t = m_sh_t; m_w_s = m_sh_s; m_k = 0; m_state = 2; m_err = 0; m_ovr = 0;
      end
    end else begin
      if (tick_i && m_k < N && (!m_full || angle_ready_i)) begin
        m_full = 1; m_angle = exp_angle(m_k); m_pidx = m_k % P; m_fidx = m_k / P; m_k++;
      end else begin
        if (tick_i && m_k < N) m_ovr = 1;
        if (m_full && angle_ready_i) begin
          m_full = 0;
          if (m_k == N) begin m_done = 1; m_state = 1; end
        end
      end
    end
    if (thetaM_valid_i) begin q = q_of(thetaM_i); m_sh_t = q[31:0]; m_lt = 1; if (q[32]) m_err = 1; end
    if (mirrorStep_valid_i) begin q = q_of(mirrorStep_i); m_sh_s = q[31:0]; m_ls = 1; if (q[32]) m_err = 1; end
  endfunction

  task automatic drive_cycle();
    @(posedge clk_i);
    model_edge();
    #1;
    start_i = 1'b0; thetaM_valid_i = 1'b0; mirrorStep_valid_i = 1'b0;
  endtask

  task automatic load_params(input logic [31:0] t, input logic [31:0] s);
    thetaM_i = t; thetaM_valid_i = 1'b1; mirrorStep_i = s; mirrorStep_valid_i = 1'b1;
    drive_cycle();
    drive_cycle();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    drive_cycle();
  endtask

  task automatic finish_sweep();
    tick_i = 1'b1; angle_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_state != 2) break;
      drive_cycle();
    end
    tick_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL finish_timeout: busy %b required 0", busy_o); end
    drive_cycle();
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if ({angle_valid_o, sweep_done_o, busy_o, conv_err_o, overrun_o} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", {angle_valid_o, sweep_done_o, busy_o, conv_err_o, overrun_o}); end
    n_cmp++; if ({angle_o, point_idx_o, frame_idx_o} !== 56'd0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {angle_o, point_idx_o, frame_idx_o}); end
    nrst_i = 1'b1;
    model_reset();
    do_start();
    drive_cycle();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL start_unloaded: busy %b required 0", busy_o); end
  endtask

  task automatic test_basic_sweep();
    logic [31:0] e;
    load_params(32'h4060_0000, 32'h3F80_0000);
    do_start();
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy_o); end
    tick_i = 1'b1; angle_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive_cycle();
      e = 32'hFC80_0000 + (32'(i) << 24);
      n_cmp++; if ({angle_valid_o, angle_o} !== {1'b1, e}) begin
        n_fail++; $display("FAIL basic_angle[%0d]: got %b/%h required 1/%h", i, angle_valid_o, angle_o, e); end
      n_cmp++; if ({point_idx_o, frame_idx_o, sweep_done_o} !== {16'(i % P), 8'(i / P), 1'b0}) begin
        n_fail++; $display("FAIL basic_idx[%0d]: got %0d/%0d/%b required %0d/%0d/0", i, point_idx_o, frame_idx_o, sweep_done_o, i % P, i / P); end
    end
    drive_cycle();
    n_cmp++; if ({sweep_done_o, angle_valid_o, busy_o} !== 3'b100) begin
      n_fail++; $display("FAIL basic_done: done/valid/busy %b required 100", {sweep_done_o, angle_valid_o, busy_o}); end
    drive_cycle();
    n_cmp++; if ({sweep_done_o, overrun_o} !== 2'b00) begin
      n_fail++; $display("FAIL basic_done_pulse: done/overrun %b required 00", {sweep_done_o, overrun_o}); end
    tick_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_start();
    tick_i = 1'b1; angle_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      n_cmp++; if ({angle_valid_o, angle_o} !== {1'b1, 32'hFC80_0000}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h required 1/fc800000", i, angle_valid_o, angle_o); end
      n_cmp++; if (overrun_o !== (i > 0)) begin
        n_fail++; $display("FAIL bp_overrun[%0d]: got %b required %b", i, overrun_o, i > 0); end
    end
    angle_ready_i = 1'b1;
    drive_cycle();
    n_cmp++; if (angle_o !== 32'hFD80_0000) begin n_fail++; $display("FAIL bp_second: got %h required fd800000", angle_o); end
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      n_cmp++; if ({angle_valid_o, sweep_done_o, overrun_o} !== {m_full, m_done, m_ovr}) begin
        n_fail++; $display("FAIL bp_flags[%0d]: got %b required %b", i, {angle_valid_o, sweep_done_o, overrun_o}, {m_full, m_done, m_ovr}); end
      if (m_full) begin
        n_cmp++; if (angle_o !== m_angle) begin n_fail++; $display("FAIL bp_angle[%0d]: got %h required %h", i, angle_o, m_angle); end
      end
    end
    n_cmp++; if ({busy_o, overrun_o} !== 2'b01) begin
      n_fail++; $display("FAIL bp_end: busy/overrun %b required 01", {busy_o, overrun_o}); end
    tick_i = 1'b0;
    drive_cycle();
  endtask

  task automatic test_conversion();
    logic [31:0] th [3];
    logic [31:0] ang [3];
    bit          er [3];
    th[0] = 32'h4348_0000; ang[0] = 32'h8000_0001; er[0] = 1'b1;
    th[1] = 32'h0000_0000; ang[1] = 32'h0000_0000; er[1] = 1'b0;
    th[2] = 32'h7FC0_0000; ang[2] = 32'h8000_0001; er[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_params(th[i], 32'h3F80_0000);
      n_cmp++; if (conv_err_o !== er[i]) begin n_fail++; $display("FAIL conv_err[%0d]: got %b required %b", i, conv_err_o, er[i]); end
      do_start();
      n_cmp++; if (conv_err_o !== 1'b0) begin n_fail++; $display("FAIL conv_err_clear[%0d]: got %b required 0", i, conv_err_o); end
      tick_i = 1'b1; angle_ready_i = 1'b1;
      drive_cycle();
      n_cmp++; if (angle_o !== ang[i]) begin n_fail++; $display("FAIL conv_angle[%0d]: got %h required %h", i, angle_o, ang[i]); end
      finish_sweep();
    end
  endtask

  task automatic test_acc_overflow();
    logic [31:0] tab [8];
    tab[0] = 32'h9C00_0000; tab[1] = 32'hCE00_0000; tab[2] = 32'h0000_0000;
    tab[3] = 32'h3200_0000; tab[4] = 32'h6400_0000;
`ifdef MIRROR_ACC_SAT_EN
    tab[5] = 32'h7FFF_FFFF; tab[6] = 32'h7FFF_FFFF; tab[7] = 32'h7FFF_FFFF;
`else
    tab[5] = 32'h9600_0000; tab[6] = 32'hC800_0000; tab[7] = 32'hFA00_0000;
`endif
    load_params(32'h42C8_0000, 32'h4248_0000);
    do_start();
    tick_i = 1'b1; angle_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive_cycle();
      n_cmp++; if (angle_o !== tab[i]) begin n_fail++; $display("FAIL ovf_angle[%0d]: got %h required %h", i, angle_o, tab[i]); end
    end
    finish_sweep();
  endtask

  task automatic test_reset_mid_sweep();
    load_params(32'h4060_0000, 32'h3F80_0000);
    do_start();
    tick_i = 1'b1; angle_ready_i = 1'b1;
    repeat (3) drive_cycle();
    tick_i = 1'b0;
    #2 nrst_i = 1'b0;
    #1;
    n_cmp++; if ({angle_valid_o, busy_o, angle_o, point_idx_o} !== 50'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b/%b/%h/%0d required 0", angle_valid_o, busy_o, angle_o, point_idx_o); end
    model_reset();
    @(posedge clk_i); @(posedge clk_i);
    #1 nrst_i = 1'b1;
    do_start(); drive_cycle();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_start0: busy %b required 0", busy_o); end
    thetaM_i = 32'h4060_0000; thetaM_valid_i = 1'b1;
    drive_cycle(); drive_cycle();
    do_start();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_start1: busy %b required 0", busy_o); end
    mirrorStep_i = 32'h3F80_0000; mirrorStep_valid_i = 1'b1;
    drive_cycle(); drive_cycle();
    do_start();
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midreset_start2: busy %b required 1", busy_o); end
    tick_i = 1'b1;
    drive_cycle();
    n_cmp++; if ({angle_o, point_idx_o} !== {32'hFC80_0000, 16'd0}) begin
      n_fail++; $display("FAIL midreset_first: got %h/%0d required fc800000/0", angle_o, point_idx_o); end
    finish_sweep();
  endtask

  task automatic test_shadow_update();
    logic [31:0] e;
    load_params(32'h4060_0000, 32'h3F80_0000);
    do_start();
    tick_i = 1'b1; angle_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == 2) begin mirrorStep_i = 32'h4000_0000; mirrorStep_valid_i = 1'b1; end
      drive_cycle();
      e = 32'hFC80_0000 + (32'(i) << 24);
      n_cmp++; if (angle_o !== e) begin n_fail++; $display("FAIL shadow_cur[%0d]: got %h required %h", i, angle_o, e); end
    end
    finish_sweep();
    do_start();
    tick_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      e = 32'hFC80_0000 + (32'(i) << 25);
      n_cmp++; if (angle_o !== e) begin n_fail++; $display("FAIL shadow_next[%0d]: got %h required %h", i, angle_o, e); end
    end
    finish_sweep();
  endtask

  function automatic logic [31:0] rand_float(input int lo_e, input int hi_e);
    return {1'($urandom), 8'($urandom_range(hi_e, lo_e)), 23'($urandom)};
  endfunction

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      load_params(rand_float(122, 133), rand_float(115, 127));
      do_start();
      for (int c = 0; c < 200; c++) begin
        if (m_state != 2) break;
        tick_i = ($urandom % 4) != 0;
        angle_ready_i = ($urandom % 3) != 0;
        if ($urandom % 8 == 0) begin mirrorStep_i = rand_float(115, 127); mirrorStep_valid_i = 1'b1; end
        drive_cycle();
        n_cmp++; if ({angle_valid_o, sweep_done_o, overrun_o, busy_o, conv_err_o} !== {m_full, m_done, m_ovr, m_state == 2, m_err}) begin
          n_fail++; $display("FAIL rnd_flags[%0d.%0d]: got %b required %b", s, c,
            {angle_valid_o, sweep_done_o, overrun_o, busy_o, conv_err_o}, {m_full, m_done, m_ovr, m_state == 2, m_err}); end
        if (m_full) begin
          n_cmp++; if ({angle_o, point_idx_o, frame_idx_o} !== {m_angle, 16'(m_pidx), 8'(m_fidx)}) begin
            n_fail++; $display("FAIL rnd_angle[%0d.%0d]: got %h/%0d/%0d required %h/%0d/%0d", s, c,
              angle_o, point_idx_o, frame_idx_o, m_angle, m_pidx, m_fidx); end
        end
      end
      n_cmp++; if (m_state == 2) begin n_fail++; $display("FAIL rnd_timeout[%0d]: busy %b required sweep end", s, busy_o); end
      tick_i = 1'b0;
      drive_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_conversion();
    test_acc_overflow();
    test_reset_mid_sweep();
    test_shadow_update();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mirror_angle_gen.md
MIRROR_ANGLE_GEN -- requirements
Module: mirror_angle_gen

Interface
REQ-001 SHALL have parameter POINTS_PER_LINE_P, default 360, points per line (P).
REQ-002 SHALL have parameter NUMBER_OF_FRAMES_P, default 5, frames per sweep (F); N = P*F, N >= 2, N <= 65535.
REQ-003 SHALL have clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have nrst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have thetaM_valid_i / thetaM_i  input  1/32  IEEE-754 single amplitude strobe/data.
REQ-006 SHALL have mirrorStep_valid_i / mirrorStep_i  input  1/32  IEEE-754 single per-point step strobe/data.
REQ-007 SHALL have start_i  input  1  sweep start pulse.
REQ-008 SHALL have tick_i  input  1  point strobe, one angle per accepted tick.
REQ-009 SHALL have angle_ready_i  input  1  consumer ready.
REQ-010 SHALL have angle_valid_o / angle_o  output  1/32  angle, signed Q8.24.
REQ-011 SHALL have point_idx_o / frame_idx_o  output  16/8  k mod P, k div P for emitted angle.
REQ-012 SHALL have sweep_done_o  output  1  one-cycle pulse after last point accepted.
REQ-013 SHALL have busy_o, conv_err_o, overrun_o  output  1 each  RUN state, sticky conversion error, sticky dropped tick.

Function
REQ-014 SHALL convert each float input to Q8.24 registered one cycle after its valid: shift = exp-126 applied to {1,mantissa}, right-shift truncates toward zero, sign applied by two's complement.
REQ-015 SHALL map exp=0 (zero/denormal) to 0; |value| >= 128, Inf or NaN SHALL saturate to 0x7FFFFFFF/0x80000000 by sign (NaN positive) and set conv_err_o.
REQ-016 SHALL hold converted values in shadow registers with per-parameter loaded flags; updates accepted in any state.
REQ-017 SHALL implement states IDLE, READY, RUN: IDLE->READY when both loaded flags set; READY->RUN on start_i; RUN->READY after last point accepted.
REQ-018 On start_i in READY SHALL copy shadows to working registers, set acc = -thetaM_fx, k = 0; start_i in IDLE or RUN SHALL be ignored.
REQ-019 In RUN, tick_i with output slot empty or being accepted same cycle SHALL, next cycle, assert angle_valid_o with angle_o = acc, indices from k, then acc += step, k += 1.
REQ-020 angle_valid_o SHALL hold with stable data until angle_valid_o & angle_ready_i.
REQ-021 tick_i while slot full and not accepted SHALL be dropped and set overrun_o; tick_i outside RUN SHALL be ignored without flag.
REQ-022 After point k = N-1 emitted, further ticks SHALL be ignored; on its acceptance sweep_done_o SHALL pulse and state SHALL return to READY.
REQ-023 Shadow updates during RUN SHALL not affect the current sweep.
REQ-024 Accumulator addition SHALL be 32-bit signed (behaviour on overflow per REQ-029).
REQ-025 conv_err_o and overrun_o SHALL clear only on reset or start_i accepted.

Reset
REQ-026 nrst_i low SHALL immediately force state IDLE, loaded flags 0, acc/k/shadows 0.
REQ-027 During and after reset all outputs SHALL be 0; reset mid-sweep SHALL discard pending output and require both parameters reloaded.

Configuration
REQ-028 Macro MIRROR_ACC_SAT_EN SHALL select accumulator overflow handling.
REQ-029 Defined: acc += step saturates at 0x7FFFFFFF/0x80000000; undefined: two's-complement wrap.

Verification (P=4, F=2, N=8)
REQ-030 thetaM=0x40600000 (3.5), step=0x3F800000 (1.0), start, 8 ticks, ready=1 -> angle_o 0xFC800000,0xFD800000,...,0x03800000; idx (0,0)..(3,1); sweep_done_o one pulse after 8th.
REQ-031 Same sweep, angle_ready_i=0 for 3 cycles with ticks every cycle -> first angle held stable, subsequent ticks dropped, overrun_o=1.
REQ-032 thetaM=0x43480000 (200.0) -> thetaM_fx=0x7FFFFFFF, conv_err_o=1; thetaM=0x00000000 -> 0, no error.
REQ-033 thetaM=0x42C80000 (100), step=0x42480000 (50) -> k=0..4: -100..100; k=5: 0x7FFFFFFF with MIRROR_ACC_SAT_EN, wrapped 0x96000000 without.
REQ-034 nrst_i low at k=3 -> all outputs 0 immediately; start_i after reset ignored until both params reloaded.
REQ-035 New step loaded at k=2 -> current sweep unchanged; next start uses new step.
